// File: rtl/sim_event_sched.sv
// sim_event_sched: step-driven (time,value) event table driving a held output.
// Build option: SIM_EVENT_SCHED_REPEAT_EN restarts the table every period.
module sim_event_sched #(
  parameter int N_EVT = 6,
  parameter int TW    = 12,
  parameter int DW    = 64,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          sta_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [TW-1:0] cfg_time,
  input  logic [DW-1:0] cfg_value,
  input  logic [AW:0]   cfg_num,
  input  logic [TW-1:0] period,
  input  logic          arm,
  input  logic          stop,
  input  logic          step,
  output logic [TW-1:0] counter,
  output logic [DW-1:0] y,
  output logic          evt,
  output logic [AW-1:0] evt_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [AW:0] LP_NEVT = (AW+1)'(N_EVT);

  state_t        r_state;
  state_t        w_state_nx;

  logic [TW-1:0] r_time [N_EVT];
  logic [DW-1:0] r_val  [N_EVT];

  logic [AW:0]   r_num;
  logic [TW-1:0] r_period;
  logic [TW-1:0] r_counter;
  logic [DW-1:0] r_y;
  logic [AW-1:0] r_evt_idx;
  logic [AW:0]   r_idx;
  logic          r_evt;
  logic          r_done;
  logic          r_err;

  logic [AW:0]   w_num_nx;
  logic [TW-1:0] w_per_nx;
  logic [TW-1:0] w_cnt_nx;
  logic [DW-1:0] w_y_nx;
  logic [AW-1:0] w_eidx_nx;
  logic [AW:0]   w_idx_nx;
  logic          w_evt_nx;
  logic          w_done_nx;
  logic          w_err_nx;

  logic [TW-1:0] w_nxt;
  logic [TW-1:0] w_cur_time;
  logic [DW-1:0] w_cur_val;
  logic          w_hit;
  logic          w_bad;
  logic          w_wr;
  logic [AW:0]   w_num_clamp;
  logic          w_first0;

  assign w_bad = ({1'b0, cfg_addr} >= LP_NEVT);
  assign w_wr  = (r_state == S_IDLE) && cfg_we && !w_bad;

  assign w_num_clamp = (cfg_num > LP_NEVT) ? LP_NEVT : cfg_num;

  // Pending entry selected by the run pointer; pointer may equal N_EVT
  always_comb begin
    w_cur_time = '0;
    w_cur_val  = '0;
    for (int i = 0; i < N_EVT; i++) begin
      if (r_idx == (AW+1)'(i)) begin
        w_cur_time = r_time[i];
        w_cur_val  = r_val[i];
      end
    end
  end

  assign w_nxt    = r_counter + TW'(1);
  assign w_hit    = (r_idx < r_num) && (w_nxt == w_cur_time);
  assign w_first0 = (r_time[0] == '0);

  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      for (int i = 0; i < N_EVT; i++) begin
        r_time[i] <= '0;
        r_val[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_EVT; i++) begin
        if (w_wr && (cfg_addr == AW'(i))) begin
          r_time[i] <= cfg_time;
          r_val[i]  <= cfg_value;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_num_nx   = r_num;
    w_per_nx   = r_period;
    w_cnt_nx   = r_counter;
    w_y_nx     = r_y;
    w_eidx_nx  = r_evt_idx;
    w_idx_nx   = r_idx;
    w_evt_nx   = 1'b0;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_err_nx = cfg_we && (w_bad || arm);
        if (arm && !cfg_we && !stop) begin
          w_state_nx = S_RUN;
          w_num_nx   = w_num_clamp;
          w_per_nx   = period;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          if ((w_num_clamp != '0) && w_first0) begin
            w_y_nx    = r_val[0];
            w_eidx_nx = '0;
            w_idx_nx  = (AW+1)'(1);
            w_evt_nx  = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_err_nx = cfg_we || arm;
        if (stop) begin
          w_state_nx = S_IDLE;
        end else if (step) begin
          w_cnt_nx = w_nxt;
          if (w_hit) begin
            w_y_nx    = w_cur_val;
            w_eidx_nx = r_idx[AW-1:0];
            w_idx_nx  = r_idx + (AW+1)'(1);
            w_evt_nx  = 1'b1;
          end
          if (w_nxt == r_period) begin
            w_done_nx = 1'b1;
`ifdef SIM_EVENT_SCHED_REPEAT_EN
            // Wrap: a time-0 entry restarts the waveform on this edge
            w_cnt_nx = '0;
            w_idx_nx = '0;
            if ((r_num != '0) && w_first0) begin
              w_y_nx    = r_val[0];
              w_eidx_nx = '0;
              w_idx_nx  = (AW+1)'(1);
              w_evt_nx  = 1'b1;
            end
`else
            w_state_nx = S_IDLE;
`endif
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_num     <= '0;
      r_period  <= '0;
      r_counter <= '0;
      r_y       <= '0;
      r_evt_idx <= '0;
      r_idx     <= '0;
      r_evt     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_num     <= w_num_nx;
      r_period  <= w_per_nx;
      r_counter <= w_cnt_nx;
      r_y       <= w_y_nx;
      r_evt_idx <= w_eidx_nx;
      r_idx     <= w_idx_nx;
      r_evt     <= w_evt_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  assign counter = r_counter;
  assign y       = r_y;
  assign evt     = r_evt;
  assign evt_idx = r_evt_idx;
  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_sim_event_sched.sv
// tb_sim_event_sched: randomized + directed stimulus, scoreboard against
// a behavioural event-table model (both repeat and one-shot builds).
module tb_sim_event_sched;

  localparam int N  = 6;
  localparam int TW = 12;
  localparam int DW = 64;
  localparam int AW = 3;
  localparam int WRAP = 1 << TW;

  logic          clk = 1'b0;
  logic          sta_n = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [TW-1:0] cfg_time = '0;
  logic [DW-1:0] cfg_value = '0;
  logic [AW:0]   cfg_num = '0;
  logic [TW-1:0] period = '0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          step = 1'b0;

  logic [TW-1:0] counter;
  logic [DW-1:0] y;
  logic          evt;
  logic [AW-1:0] evt_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;

  sim_event_sched #(
    .N_EVT(N), .TW(TW), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk), .sta_n(sta_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_time(cfg_time), .cfg_value(cfg_value),
    .cfg_num(cfg_num), .period(period),
    .arm(arm), .stop(stop), .step(step),
    .counter(counter), .y(y), .evt(evt),
    .evt_idx(evt_idx), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] cnt;
    logic [DW-1:0] yv;
    logic          ev;
    logic [AW-1:0] idx;
    logic          bsy;
    logic          dn;
    logic          err;
  } obs_t;

  obs_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int          mt[N];
  logic [63:0] mv[N];
  bit          m_run;
  int          m_cnt, m_ptr, m_num, m_per, m_eidx;
  logic [63:0] m_y;
  bit          m_evt, m_done, m_err;

  function automatic obs_t sample();
    obs_t o;
    o.cnt = counter; o.yv = y; o.ev = evt; o.idx = evt_idx;
    o.bsy = busy; o.dn = done; o.err = cfg_err;
    return o;
  endfunction

  function automatic obs_t mk(int c, logic [63:0] v, bit e, int i,
                              bit b, bit d, bit r);
    obs_t o;
    o.cnt = TW'(c); o.yv = v; o.ev = e; o.idx = AW'(i);
    o.bsy = b; o.dn = d; o.err = r;
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t g, input obs_t w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s: got cnt=%0d y=%h evt=%b idx=%0d busy=%b done=%b err=%b | want cnt=%0d y=%h evt=%b idx=%0d busy=%b done=%b err=%b",
        nm, g.cnt, g.yv, g.ev, g.idx, g.bsy, g.dn, g.err,
        w.cnt, w.yv, w.ev, w.idx, w.bsy, w.dn, w.err);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      mt[i] = 0; mv[i] = '0;
    end
    m_run = 0; m_cnt = 0; m_ptr = 0; m_num = 0; m_per = 0;
    m_eidx = 0; m_y = '0; m_evt = 0; m_done = 0; m_err = 0;
  endtask

  task automatic m_apply(input int i);
    m_y = mv[i]; m_eidx = i; m_ptr = i + 1; m_evt = 1;
  endtask

  // One clock edge of the scheduler's defined behaviour
  task automatic model();
    int nxt;
    m_evt = 0; m_done = 0; m_err = 0;
    if (!m_run) begin
      if (cfg_we) begin
        if (int'(cfg_addr) >= N) m_err = 1;
        else begin
          mt[cfg_addr] = int'(cfg_time);
          mv[cfg_addr] = cfg_value;
        end
        if (arm) m_err = 1;
      end else if (arm && !stop) begin
        m_run = 1;
        m_num = (int'(cfg_num) > N) ? N : int'(cfg_num);
        m_per = int'(period);
        m_cnt = 0; m_ptr = 0;
        if (m_num > 0 && mt[0] == 0) m_apply(0);
      end
    end else begin
      m_err = cfg_we || arm;
      if (stop) m_run = 0;
      else if (step) begin
        nxt = (m_cnt + 1) % WRAP;
        m_cnt = nxt;
        if (m_ptr < m_num && mt[m_ptr] == nxt) m_apply(m_ptr);
        if (nxt == m_per) begin
          m_done = 1;
`ifdef SIM_EVENT_SCHED_REPEAT_EN
          m_cnt = 0; m_ptr = 0;
          if (m_num > 0 && mt[0] == 0) m_apply(0);
`else
          m_run = 0;
`endif
        end
      end
    end
    sbq.push_back(mk(m_cnt, m_y, m_evt, m_eidx, m_run, m_done, m_err));
  endtask

  // Caller is at a negedge with inputs set
  task automatic tick();
    model();
    @(negedge clk);
    cfg_we = 0; arm = 0; stop = 0; step = 0;
  endtask

  task automatic wr(input int a, input int t, input logic [63:0] v);
    cfg_we = 1; cfg_addr = AW'(a); cfg_time = TW'(t); cfg_value = v;
    tick();
  endtask

  task automatic do_arm(input int n, input int p, input bit s);
    arm = 1; cfg_num = (AW+1)'(n); period = TW'(p); step = s;
    tick();
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      step = 1;
      tick();
    end
  endtask

  task automatic halt();
    stop = 1;
    tick();
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sbq.size() > 0) chk($sformatf("sb%0d", checks), sample(), sbq.pop_front());
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] A, B, C, X;
    A = 64'hA5A5_0000_1111_0001;
    B = 64'hB6B6_0000_2222_0002;
    C = 64'hC7C7_0000_3333_0003;
    X = 64'hDEAD_BEEF_0BAD_F00D;
    m_reset();
    #1 sta_n = 0;
    repeat (2) @(negedge clk);
    chk("reset", sample(), mk(0, '0, 0, 0, 0, 0, 0));
    sta_n = 1;
    @(negedge clk);

    // Basic table run
    wr(0, 0, A); wr(1, 3, B); wr(2, 5, C);
    do_arm(3, 8, 0);
    steps(8);
`ifdef SIM_EVENT_SCHED_REPEAT_EN
    chk("run_end", sample(), mk(0, A, 1, 0, 1, 1, 0));
    steps(3);
    chk("rep_b", sample(), mk(3, B, 1, 1, 1, 0, 0));
    halt();
`else
    chk("run_end", sample(), mk(8, C, 0, 2, 0, 1, 0));
`endif
    repeat (2) tick();

    // Rejected writes: in RUN and out-of-range address in IDLE
    do_arm(3, 8, 0);
    steps(2);
    wr(1, 9, X);
    steps(6);
    halt();
    wr(7, 1, X);
    wr(6, 1, X);
    do_arm(3, 8, 0);
    steps(8);
    halt();

    // Stop together with a step at count 4
    do_arm(3, 8, 0);
    steps(4);
    stop = 1; step = 1;
    tick();
    chk("stop_hold", sample(), mk(4, B, 0, 1, 0, 0, 0));
    repeat (2) tick();

    // Duplicate times; step coincident with arm is ignored
    wr(0, 2, A); wr(1, 2, B);
    do_arm(2, 6, 1);
    steps(7);
    halt();

    // Period 0 ends only after a full counter wrap
    do_arm(3, 0, 0);
    steps(WRAP);
    halt();

    // Asynchronous reset mid-run
    wr(0, 0, A); wr(1, 3, B);
    do_arm(3, 20, 0);
    steps(6);
    sta_n = 0;
    #1;
    chk("async_rst", sample(), mk(0, '0, 0, 0, 0, 0, 0));
    m_reset();
    @(negedge clk);
    sta_n = 1;
    do_arm(0, 5, 0);
    steps(3);
    halt();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (!m_run) begin
        if (r < 8) begin
          int t;
          t = $urandom_range(0, 1);
          for (int i = 0; i < N; i++) begin
            wr(i, t, {$urandom, $urandom});
            t += $urandom_range(0, 4);
          end
        end else if (r < 14) begin
          wr($urandom_range(0, 7), $urandom_range(0, 30), {$urandom, $urandom});
        end else if (r < 18) begin
          cfg_we = 1; cfg_addr = AW'($urandom_range(0, 7));
          cfg_time = TW'($urandom_range(0, 9)); cfg_value = {$urandom, $urandom};
          arm = 1;
          tick();
        end else if (r < 20) begin
          stop = 1; arm = 1; step = 1;
          tick();
        end else begin
          do_arm($urandom_range(0, 7), $urandom_range(1, 30), $urandom_range(0, 1));
        end
      end else begin
        cfg_we = (r < 3);
        arm = (r >= 3 && r < 5);
        stop = (r >= 5 && r < 8);
        step = ($urandom_range(0, 3) != 0);
        cfg_addr = AW'($urandom_range(0, 5));
        cfg_time = TW'($urandom_range(0, 30));
        cfg_value = {$urandom, $urandom};
        tick();
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sim_event_sched.md
# sim_event_sched

Time-step event scheduler for the PV real-time simulation datapath. Holds a programmable table of up to `N_EVT` (time, value) entries. Counts simulation time steps and drives a registered output value that changes to each entry's value when the step counter reaches that entry's time. It sequences the piecewise-constant source/control waveforms fed into the solver, replacing fixed hard-wired event tables with a run-time configurable one.

## Interface
- `N_EVT`, 6, table depth (2..16)
- `TW`, 12, step-counter and event-time width
- `DW`, 64, value width (`EXTENDED_SINGLE`)
- `AW`, 3, table address width, ≥ clog2(`N_EVT`)

- `clk` in 1: system clock, all logic on rising edge
- `sta_n` in 1: asynchronous active-low reset
- `cfg_we` in 1: table write strobe, honoured only in IDLE
- `cfg_addr` in AW: entry index
- `cfg_time` in TW: entry event time
- `cfg_value` in DW: entry value
- `cfg_num` in AW+1: number of valid entries, sampled on `arm`
- `period` in TW: run length in steps, sampled on `arm`
- `arm` in 1: start run, honoured only in IDLE
- `stop` in 1: abort run, return to IDLE
- `step` in 1: one-cycle simulation-step strobe
- `counter` out TW: current step count
- `y` out DW: active value
- `evt` out 1: one-cycle pulse when `y` is loaded from the table
- `evt_idx` out AW: index of last applied entry
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse on run completion
- `cfg_err` out 1: one-cycle pulse when `cfg_we` or `arm` is rejected

## Operation
- States: IDLE, RUN. Reset → IDLE; table entries, `counter`, `y`, `evt_idx`, `idx` and all pulses are 0; `busy`=0.
- IDLE:
  - `cfg_we` writes entry `cfg_addr`. An address ≥ `N_EVT` is dropped and raises `cfg_err`.
  - `arm` latches `cfg_num` (clamped to `N_EVT`) and `period`, clears `counter` and `idx`, and enters RUN.
  - At the arm edge, if `cfg_num`>0 and entry 0 time is 0, then `y`←value0, `evt`=1, and `idx`←1.
- RUN:
  - On each `step`, `nxt`=`counter`+1 (mod 2^TW) and `counter`←`nxt`.
  - If `idx`<num and `nxt`==time[`idx`], then `y`←value[`idx`], `evt_idx`←`idx`, `idx`←`idx`+1, `evt`=1.
  - At most one entry is applied per step. Entries must have strictly ascending times; an out-of-order or duplicate entry is never matched and stalls later entries (defined behaviour, no recovery).
  - When `nxt`==`period`, the run ends; see Configuration. A `period` of 0 ends the run only after a 2^TW wrap.
  - `cfg_we` or `arm` in RUN is ignored and pulses `cfg_err`.
- `stop` (any state) → IDLE next edge; `y`, `counter`, `evt_idx` hold; no `done`. `stop` wins over a simultaneous `step` and `arm`.
- `y` holds between events and after the run ends until the next arm.
- `sta_n` low mid-run clears everything asynchronously; the table must be reprogrammed.

## Timing
- `step` sampled at edge k → `counter`, `y`, `evt`, `evt_idx` valid after edge k (registered, 1-cycle latency).
- `evt` and `done` are one cycle wide, coincident with the `y`/`counter` update.
- A `step` in the same cycle as `arm` is ignored; counting starts with the next `step`.
- A back-to-back `step` every cycle is supported; consecutive events may occur on consecutive cycles.
- `cfg_we` → entry readable by the match logic on the following cycle; writing and arming in the same cycle is illegal (write wins, `arm` ignored, `cfg_err`).

## Configuration
- `SIM_EVENT_SCHED_REPEAT_EN` defined:
  - At `nxt`==`period`, `counter`←0, `idx`←0, `done` pulses, and the FSM stays in RUN.
  - An entry with time 0 is applied on that same edge (periodic waveform).
- Undefined:
  - At `nxt`==`period`, `counter`←`period`, `done` pulses, and the FSM goes to IDLE.
  - An entry whose time equals `period` is still applied on that edge.

## Test plan
- Reset → program table {(0,A),(3,B),(5,C)}, `cfg_num`=3, `period`=8, arm → `y`=A at arm edge; `y`=B after 3rd `step`, C after 5th; `evt` pulses ×3; `done` after 8th step; `busy`=0 (repeat off).
- Same table, `SIM_EVENT_SCHED_REPEAT_EN` on → after step 8, `counter`=0, `y`=A, `done`=1, `busy`=1; second cycle repeats B at step 11 overall.
- `cfg_we` during RUN, and `cfg_addr`=7 with `N_EVT`=6 in IDLE → `cfg_err` pulse each time; table unchanged.
- `stop` asserted together with `step` at count 4 → IDLE; `counter`=4, `y`=B held; no `evt`, no `done`.
- Duplicate times {(2,A),(2,B)} → `y`=A at step 2; B is never applied; `done` at `period`.
- `sta_n` pulsed low mid-run at count 6 → all outputs 0 immediately; a subsequent arm with the table unwritten gives `y`=0 and no `evt`.
